// File: rtl/npc_mc_core.sv
// npc_mc_core: multi-cycle RV32I/E subset core (LUI, AUIPC, JAL, JALR, ADDI,
// ADD, SUB, EBREAK) with a valid/ack instruction-fetch handshake.
// Each instruction takes one FETCH phase (>= 1 cycle, bounded by FETCH_TIMEOUT)
// and one EXEC cycle; retirement is reported on the commit port one cycle later.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   inst_req/inst_addr  fetch request and address (address = pc)
//   inst_valid/inst     instruction return, captured while inst_req is high
//   pc                  architectural program counter
//   commit_*            one-cycle retirement report (pc, rd, written value)
//   halted/halt_code    stop indication: 1 good trap, 2 bad trap, 3 illegal,
//                       4 fetch timeout, 5 misaligned jump target
module npc_mc_core #(
  parameter int                XLEN          = 32,
  parameter int                NR_GPR        = 32,
  parameter logic [XLEN-1:0]   RESET_PC      = 32'h8000_0000,
  parameter int                FETCH_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  output logic            inst_req,
  output logic [XLEN-1:0] inst_addr,
  input  logic            inst_valid,
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  output logic            commit_valid,
  output logic [XLEN-1:0] commit_pc,
  output logic [4:0]      commit_rd,
  output logic [XLEN-1:0] commit_wdata,
  output logic            halted,
  output logic [2:0]      halt_code
);

  if (XLEN != 32) begin : g_xlen_chk
    $error("npc_mc_core: only XLEN=32 is supported");
  end
  if (NR_GPR != 32 && NR_GPR != 16) begin : g_gpr_chk
    $error("npc_mc_core: NR_GPR must be 32 or 16");
  end

  localparam int          IDX_W    = $clog2(NR_GPR);
  localparam logic [5:0]  NR_GPR_L = 6'(NR_GPR);
  localparam logic [31:0] TMO      = 32'(FETCH_TIMEOUT);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  state_t          state, state_nxt;
  logic [2:0]      halt_code_q, halt_code_nxt;
  logic [31:0]     tmo_cnt;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     ir_p0;
  logic [XLEN-1:0] gpr [NR_GPR];

  logic            vld_p1;
  logic [XLEN-1:0] commit_pc_p1, commit_wdata_p1;
  logic [4:0]      commit_rd_p1;

  function automatic logic idx_ok(input logic [4:0] idx);
    return {1'b0, idx} < NR_GPR_L;
  endfunction

  // ---- p0: decode of the captured instruction (valid during EXEC) ----
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] imm_i, imm_u, imm_j;
  logic [XLEN-1:0] rs1_val, rs2_val, a0_val;
  logic            is_lui, is_auipc, is_jal, is_jalr, is_addi, is_add, is_sub;
  logic            is_ebreak, uses_rd, uses_rs1, uses_rs2, legal;

  assign opcode = ir_p0[6:0];
  assign rd     = ir_p0[11:7];
  assign funct3 = ir_p0[14:12];
  assign rs1    = ir_p0[19:15];
  assign rs2    = ir_p0[24:20];
  assign funct7 = ir_p0[31:25];
  assign imm_i  = {{20{ir_p0[31]}}, ir_p0[31:20]};
  assign imm_u  = {ir_p0[31:12], 12'b0};
  assign imm_j  = {{11{ir_p0[31]}}, ir_p0[31], ir_p0[19:12], ir_p0[20], ir_p0[30:21], 1'b0};

  assign is_lui    = (opcode == 7'b0110111);
  assign is_auipc  = (opcode == 7'b0010111);
  assign is_jal    = (opcode == 7'b1101111);
  assign is_jalr   = (opcode == 7'b1100111) && (funct3 == 3'b000);
  assign is_addi   = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_add    = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign is_sub    = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
  assign is_ebreak = (ir_p0 == 32'h0010_0073);

  assign uses_rs2 = is_add | is_sub;
  assign uses_rs1 = is_jalr | is_addi | uses_rs2;
  assign uses_rd  = is_lui | is_auipc | is_jal | uses_rs1;

  // Register indices beyond NR_GPR (RV32E) make an otherwise valid encoding illegal.
  assign legal = is_ebreak ||
                 (uses_rd && idx_ok(rd) && (!uses_rs1 || idx_ok(rs1)) &&
                  (!uses_rs2 || idx_ok(rs2)));

  assign rs1_val = (rs1 != 5'd0 && idx_ok(rs1)) ? gpr[rs1[IDX_W-1:0]] : '0;
  assign rs2_val = (rs2 != 5'd0 && idx_ok(rs2)) ? gpr[rs2[IDX_W-1:0]] : '0;
  assign a0_val  = gpr[IDX_W'(10)];

  // ---- p0 -> p1: execute, retire and write back at the closing EXEC edge ----
  logic [XLEN-1:0] wdata, target, pc_plus4;
  logic            is_jump, misaligned, retire, wr_en;

  assign pc_plus4 = pc_q + XLEN'(4);

  always_comb begin
    wdata   = '0;
    target  = pc_plus4;
    is_jump = 1'b0;
    if (is_lui) begin
      wdata = imm_u;
    end else if (is_auipc) begin
      wdata = pc_q + imm_u;
    end else if (is_jal) begin
      wdata   = pc_plus4;
      target  = pc_q + imm_j;
      is_jump = 1'b1;
    end else if (is_jalr) begin
      // Link value comes from the old pc, target from the old rs1, so rd==rs1 is safe.
      wdata   = pc_plus4;
      target  = (rs1_val + imm_i) & ~XLEN'(1);
      is_jump = 1'b1;
    end else if (is_addi) begin
      wdata = rs1_val + imm_i;
    end else if (is_add) begin
      wdata = rs1_val + rs2_val;
    end else if (is_sub) begin
      wdata = rs1_val - rs2_val;
    end
  end

  assign misaligned = is_jump && target[1];
  assign retire     = (state == S_EXEC) && legal && !misaligned && !rst;
  assign wr_en      = retire && uses_rd && (rd != 5'd0);

  always_comb begin
    state_nxt     = state;
    halt_code_nxt = halt_code_q;
    unique case (state)
      S_FETCH: begin
        if (inst_valid) begin
          state_nxt = S_EXEC;
        end else if (TMO != 32'd0 && (tmo_cnt + 32'd1) == TMO) begin
          state_nxt     = S_HALT;
          halt_code_nxt = 3'd4;
        end
      end
      S_EXEC: begin
        if (!legal) begin
          state_nxt     = S_HALT;
          halt_code_nxt = 3'd3;
        end else if (misaligned) begin
          state_nxt     = S_HALT;
          halt_code_nxt = 3'd5;
        end else if (is_ebreak) begin
          state_nxt     = S_HALT;
          halt_code_nxt = (a0_val == '0) ? 3'd1 : 3'd2;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      halt_code_q <= 3'd0;
      tmo_cnt     <= 32'd0;
      pc_q        <= RESET_PC;
      vld_p1      <= 1'b0;
    end else begin
      state       <= state_nxt;
      halt_code_q <= halt_code_nxt;
      tmo_cnt     <= (state == S_FETCH && !inst_valid) ? tmo_cnt + 32'd1 : 32'd0;
      if (retire) begin
        pc_q <= target;
      end
      vld_p1 <= retire;
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_FETCH && inst_valid) begin
      ir_p0 <= inst;
    end
    if (wr_en) begin
      gpr[rd[IDX_W-1:0]] <= wdata;
    end
    if (retire) begin
      commit_pc_p1    <= pc_q;
      commit_rd_p1    <= wr_en ? rd : 5'd0;
      commit_wdata_p1 <= wr_en ? wdata : '0;
    end
  end

  // ---- p1: outputs; commit fields read zero whenever no commit is reported ----
  always_comb begin
    inst_req     = (state == S_FETCH);
    halted       = (state == S_HALT);
    inst_addr    = pc_q;
    pc           = pc_q;
    halt_code    = halt_code_q;
    commit_valid = vld_p1;
    commit_pc    = vld_p1 ? commit_pc_p1 : '0;
    commit_rd    = vld_p1 ? commit_rd_p1 : 5'd0;
    commit_wdata = vld_p1 ? commit_wdata_p1 : '0;
  end

endmodule

// File: tb/tb_npc_mc_core.sv
// Bench for npc_mc_core built as RV32E (NR_GPR=16) with FETCH_TIMEOUT=4 so the
// register-range and timeout behaviour are reachable in one configuration.
module tb_npc_mc_core;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_valid = 1'b0;
  logic [31:0] inst = 32'h0;
  logic [31:0] pc;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [4:0]  commit_rd;
  logic [31:0] commit_wdata;
  logic        halted;
  logic [2:0]  halt_code;

  always #5 clk = ~clk;

  npc_mc_core #(
    .XLEN(32), .NR_GPR(16), .RESET_PC(RPC), .FETCH_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_valid(inst_valid), .inst(inst),
    .pc(pc),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_rd(commit_rd), .commit_wdata(commit_wdata),
    .halted(halted), .halt_code(halt_code)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } commit_t;

  commit_t exp_q[$];
  commit_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every reported commit must match the oldest expected entry.
  always @(negedge clk) begin
    if (commit_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL commit_unexpected: got pc=%h rd=%0d wdata=%h, required no commit",
                 commit_pc, commit_rd, commit_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (commit_pc !== mon_e.pc || commit_rd !== mon_e.rd || commit_wdata !== mon_e.wdata) begin
          n_fail++;
          $display("FAIL commit_fields: got pc=%h rd=%0d wdata=%h, required pc=%h rd=%0d wdata=%h",
                   commit_pc, commit_rd, commit_wdata, mon_e.pc, mon_e.rd, mon_e.wdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, 3'b000, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_jal(input logic [20:0] off, input logic [4:0] rd);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    inst_valid = 1'b0;
    inst       = 32'h0;
    step();
    rst = 1'b0;
  endtask

  // Serve one fetch at exp_addr after dly idle cycles; leaves the core in EXEC.
  task automatic fetch(input logic [31:0] w, input int dly, input logic [31:0] exp_addr,
                       input string tag);
    int guard;
    guard = 0;
    while (inst_req !== 1'b1 && guard < 10) begin
      step();
      guard++;
    end
    n_checks++;
    if (inst_req !== 1'b1 || inst_addr !== exp_addr) begin
      n_fail++;
      $display("FAIL %s_fetch_req: got req=%b addr=%h, required req=1 addr=%h",
               tag, inst_req, inst_addr, exp_addr);
    end
    for (int i = 0; i < dly; i++) begin
      step();
      n_checks++;
      if (inst_req !== 1'b1 || inst_addr !== exp_addr || commit_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_fetch_hold: got req=%b addr=%h commit=%b, required req=1 addr=%h commit=0",
                 tag, inst_req, inst_addr, commit_valid, exp_addr);
      end
    end
    inst       = w;
    inst_valid = 1'b1;
    step();
    inst_valid = 1'b0;
    inst       = 32'h0;
  endtask

  task automatic exec_one(input logic [31:0] w, input logic [31:0] addr, input logic exp_commit,
                          input logic [4:0] rd, input logic [31:0] wd, input string tag,
                          input int dly = 0);
    if (exp_commit) exp_q.push_back(commit_t'{pc: addr, rd: rd, wdata: wd});
    fetch(w, dly, addr, tag);
    n_checks++;
    if (commit_valid !== 1'b0 || inst_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_exec_cycle: got commit=%b req=%b, required commit=0 req=0",
               tag, commit_valid, inst_req);
    end
    step();
    n_checks++;
    if (commit_valid !== exp_commit) begin
      n_fail++;
      $display("FAIL %s_commit_pulse: got %b, required %b", tag, commit_valid, exp_commit);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (inst_req !== 1'b1 || inst_addr !== RPC || pc !== RPC) begin
      n_fail++;
      $display("FAIL reset_fetch: got req=%b addr=%h pc=%h, required req=1 addr=%h pc=%h",
               inst_req, inst_addr, pc, RPC, RPC);
    end
    n_checks++;
    if (halted !== 1'b0 || halt_code !== 3'd0 || commit_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: got halted=%b code=%0d commit=%b, required 0 0 0",
               halted, halt_code, commit_valid);
    end
    n_checks++;
    if (commit_pc !== 32'h0 || commit_rd !== 5'd0 || commit_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_commit_fields: got pc=%h rd=%0d wdata=%h, required zeros",
               commit_pc, commit_rd, commit_wdata);
    end
  endtask

  task automatic test_alu();
    int t0;
    do_reset();
    exec_one(enc_i(12'd5, 5'd0, 5'd1, 7'b0010011), RPC, 1'b1, 5'd1, 32'd5, "addi_x1");
    t0 = cyc;
    exec_one(enc_i(12'hFF9, 5'd1, 5'd2, 7'b0010011), RPC + 4, 1'b1, 5'd2, 32'hFFFF_FFFE, "addi_x2");
    n_checks++;
    if (cyc - t0 !== 2) begin
      n_fail++;
      $display("FAIL alu_cadence: got %0d cycles between commits, required 2", cyc - t0);
    end
    exec_one(enc_r(7'b0100000, 5'd2, 5'd1, 5'd3), RPC + 8, 1'b1, 5'd3, 32'd7, "sub_x3");
    n_checks++;
    if (pc !== RPC + 12 || inst_addr !== RPC + 12) begin
      n_fail++;
      $display("FAIL alu_pc: got pc=%h addr=%h, required %h", pc, inst_addr, RPC + 12);
    end
  endtask

  task automatic test_upper();
    do_reset();
    exec_one(enc_u(20'hABCDE, 5'd5, 7'b0110111), RPC, 1'b1, 5'd5, 32'hABCD_E000, "lui");
    exec_one(enc_u(20'h00001, 5'd6, 7'b0010111), RPC + 4, 1'b1, 5'd6, 32'h8000_1004, "auipc");
    exec_one(enc_r(7'b0000000, 5'd6, 5'd5, 5'd7), RPC + 8, 1'b1, 5'd7, 32'h2BCD_F004, "add_wrap");
  endtask

  task automatic test_jump();
    do_reset();
    exec_one(enc_jal(21'd8, 5'd1), RPC, 1'b1, 5'd1, RPC + 4, "jal");
    n_checks++;
    if (inst_addr !== RPC + 8) begin
      n_fail++;
      $display("FAIL jal_target: got %h, required %h", inst_addr, RPC + 8);
    end
    exec_one(enc_i(12'd1, 5'd1, 5'd0, 7'b1100111), RPC + 8, 1'b1, 5'd0, 32'h0, "jalr_lsb");
    n_checks++;
    if (pc !== RPC + 4) begin
      n_fail++;
      $display("FAIL jalr_target: got %h, required %h", pc, RPC + 4);
    end
    exec_one(enc_i(12'hFFE, 5'd1, 5'd0, 7'b1100111), RPC + 4, 1'b0, 5'd0, 32'h0, "jalr_misalign");
    n_checks++;
    if (halted !== 1'b1 || halt_code !== 3'd5 || inst_req !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_halt: got halted=%b code=%0d req=%b, required 1 5 0",
               halted, halt_code, inst_req);
    end
  endtask

  task automatic test_jalr_same_reg();
    do_reset();
    exec_one(enc_u(20'h80000, 5'd1, 7'b0110111), RPC, 1'b1, 5'd1, 32'h8000_0000, "lui_x1");
    exec_one(enc_i(12'd16, 5'd1, 5'd1, 7'b1100111), RPC + 4, 1'b1, 5'd1, RPC + 8, "jalr_rd_eq_rs1");
    n_checks++;
    if (pc !== RPC + 16) begin
      n_fail++;
      $display("FAIL jalr_same_target: got %h, required %h", pc, RPC + 16);
    end
  endtask

  task automatic test_fetch_timeout();
    do_reset();
    exec_one(enc_i(12'd1, 5'd0, 5'd1, 7'b0010011), RPC, 1'b1, 5'd1, 32'd1, "delayed3", 3);
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (halted !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_early: got halted=1 after %0d idle cycles, required 0", i + 1);
      end
    end
    step();
    n_checks++;
    if (halted !== 1'b1 || halt_code !== 3'd4 || inst_req !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_halt: got halted=%b code=%0d req=%b, required 1 4 0",
               halted, halt_code, inst_req);
    end
    inst       = enc_i(12'd2, 5'd0, 5'd2, 7'b0010011);
    inst_valid = 1'b1;
    step();
    step();
    inst_valid = 1'b0;
    n_checks++;
    if (halted !== 1'b1 || halt_code !== 3'd4 || pc !== RPC + 4 || commit_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_hold: got halted=%b code=%0d pc=%h commit=%b, required 1 4 %h 0",
               halted, halt_code, pc, commit_valid, RPC + 4);
    end
  endtask

  task automatic test_x0_and_rv32e();
    do_reset();
    exec_one(enc_i(12'd9, 5'd0, 5'd0, 7'b0010011), RPC, 1'b1, 5'd0, 32'h0, "addi_x0");
    exec_one(enc_r(7'b0000000, 5'd0, 5'd0, 5'd4), RPC + 4, 1'b1, 5'd4, 32'h0, "x0_reads_0");
    exec_one(enc_i(12'd1, 5'd0, 5'd20, 7'b0010011), RPC + 8, 1'b0, 5'd0, 32'h0, "rv32e_x20");
    n_checks++;
    if (halted !== 1'b1 || halt_code !== 3'd3) begin
      n_fail++;
      $display("FAIL illegal_halt: got halted=%b code=%0d, required 1 3", halted, halt_code);
    end
  endtask

  task automatic test_ebreak();
    do_reset();
    exec_one(enc_i(12'd0, 5'd0, 5'd10, 7'b0010011), RPC, 1'b1, 5'd10, 32'h0, "a0_zero");
    exec_one(32'h0010_0073, RPC + 4, 1'b1, 5'd0, 32'h0, "ebreak_good");
    n_checks++;
    if (halted !== 1'b1 || halt_code !== 3'd1) begin
      n_fail++;
      $display("FAIL good_trap: got halted=%b code=%0d, required 1 1", halted, halt_code);
    end
    do_reset();
    n_checks++;
    if (halted !== 1'b0 || halt_code !== 3'd0 || inst_req !== 1'b1 || inst_addr !== RPC) begin
      n_fail++;
      $display("FAIL reset_from_halt: got halted=%b code=%0d req=%b addr=%h, required 0 0 1 %h",
               halted, halt_code, inst_req, inst_addr, RPC);
    end
    exec_one(enc_i(12'd3, 5'd0, 5'd10, 7'b0010011), RPC, 1'b1, 5'd10, 32'd3, "a0_three");
    exec_one(32'h0010_0073, RPC + 4, 1'b1, 5'd0, 32'h0, "ebreak_bad");
    n_checks++;
    if (halted !== 1'b1 || halt_code !== 3'd2) begin
      n_fail++;
      $display("FAIL bad_trap: got halted=%b code=%0d, required 1 2", halted, halt_code);
    end
  endtask

  task automatic test_reset_pending();
    do_reset();
    step();
    step();
    rst        = 1'b1;
    inst_valid = 1'b1;
    inst       = enc_i(12'd7, 5'd0, 5'd1, 7'b0010011);
    step();
    rst        = 1'b0;
    inst_valid = 1'b0;
    inst       = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (inst_req !== 1'b1 || inst_addr !== RPC || halted !== 1'b0 || commit_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_abandon: got req=%b addr=%h halted=%b commit=%b, required 1 %h 0 0",
                 inst_req, inst_addr, halted, commit_valid, RPC);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_upper();
    test_jump();
    test_jalr_same_reg();
    test_fetch_timeout();
    test_x0_and_rv32e();
    test_ebreak();
    test_reset_pending();
    step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d commits outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
